// File: rtl/tff_pkg.sv
// Shared helpers for the toggle flip-flop bank.
// Holds the next-state rule so every bit slice uses the same toggle equation.
package tff_pkg;

    // Next state of one toggle bit out of reset. An X or Z on t gives an X result.
    function automatic logic toggle_next(input logic q, input logic t);
        return q ^ t;
    endfunction

endpackage

// File: rtl/tff_bit.sv
// Single toggle flop with synchronous active-high reset to a per-bit load value.
// q is driven directly from the flop, so it has no combinational path and cannot glitch.
module tff_bit
    import tff_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic t,
    input  logic rst_val,
    output logic q
);

    // The reset input is named reset_n but is active-high: 1 loads rst_val and ignores t.
    // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            q <= rst_val;
        end else begin
            q <= toggle_next(q, t);
        end
    end

endmodule

// File: rtl/tff.sv
// Bank of WIDTH independent toggle flip-flops: q[i] inverts on posedge clk when T[i] is 1.
// Synchronous active-high reset (reset_n == 1) loads RESET_VAL and takes priority over T.
module tff #(
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic [WIDTH-1:0] T,
    input  logic             clk,
    input  logic             reset_n,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_bit u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .t       (T[i]),
            .rst_val (RESET_VAL[i]),
            .q       (q[i])
        );
    end

endmodule

// File: tb/tb_tff.sv
// Self-checking bench for tff at WIDTH=1 and WIDTH=4 (zero and non-zero reset values).
// A per-edge expected state is queued when inputs are driven and popped once the edge has passed.
module tb_tff;

    localparam logic [3:0] RST_ALT = 4'b1001;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [0:0] t1;
    logic [3:0] t4;
    logic [0:0] q1;
    logic [3:0] q4;
    logic [3:0] q4r;

    always #25 clk = ~clk;

    tff #(.WIDTH(1)) dut1 (
        .T       (t1),
        .clk     (clk),
        .reset_n (reset_n),
        .q       (q1)
    );

    tff #(.WIDTH(4)) dut4 (
        .T       (t4),
        .clk     (clk),
        .reset_n (reset_n),
        .q       (q4)
    );

    tff #(.WIDTH(4), .RESET_VAL(RST_ALT)) dut4r (
        .T       (t4),
        .clk     (clk),
        .reset_n (reset_n),
        .q       (q4r)
    );

    logic [8:0] sb[$];
    logic [8:0] exp_q;
    logic [0:0] e1;
    logic [3:0] e4;
    logic [3:0] e4r;
    int         compared   = 0;
    int         mismatched = 0;

    // Drive one edge's inputs away from posedge, advance the model, queue its result,
    // then stop 1 ns after the edge so outputs can be sampled.
    task automatic drive(input logic rst, input logic [0:0] nt1, input logic [3:0] nt4);
        @(negedge clk);
        reset_n = rst;
        t1      = nt1;
        t4      = nt4;
        e1      = rst ? 1'b0    : (e1 ^ nt1);
        e4      = rst ? 4'b0000 : (e4 ^ nt4);
        e4r     = rst ? RST_ALT : (e4r ^ nt4);
        sb.push_back({e1, e4, e4r});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 4'hF);
            exp_q = sb.pop_front();
            compared++;
            if ({q1, q4, q4r} !== exp_q) begin
                mismatched++;
                $display("FAIL reset edge %0d: got %b required %b", i, {q1, q4, q4r}, exp_q);
            end
        end
        compared++;
        if (q4r !== RST_ALT) begin
            mismatched++;
            $display("FAIL reset_val_load: got %b required %b", q4r, RST_ALT);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 4'h0);
            exp_q = sb.pop_front();
            compared++;
            if ({q1, q4, q4r} !== exp_q) begin
                mismatched++;
                $display("FAIL hold edge %0d: got %b required %b", i, {q1, q4, q4r}, exp_q);
            end
        end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 4'hF);
            exp_q = sb.pop_front();
            compared++;
            if ({q1, q4, q4r} !== exp_q) begin
                mismatched++;
                $display("FAIL toggle edge %0d: got %b required %b", i, {q1, q4, q4r}, exp_q);
            end
        end
    endtask

    task automatic test_mixed();
        drive(1'b1, 1'b0, 4'h0);
        exp_q = sb.pop_front();
        drive(1'b0, 1'b0, 4'b1010);
        exp_q = sb.pop_front();
        compared++;
        if (q4 !== 4'b1010 || {q1, q4, q4r} !== exp_q) begin
            mismatched++;
            $display("FAIL mixed_1010: got %b required %b", {q1, q4, q4r}, exp_q);
        end
        drive(1'b0, 1'b0, 4'b0110);
        exp_q = sb.pop_front();
        compared++;
        if (q4 !== 4'b1100 || {q1, q4, q4r} !== exp_q) begin
            mismatched++;
            $display("FAIL mixed_0110: got %b required %b", {q1, q4, q4r}, exp_q);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, 4'h0);
        exp_q = sb.pop_front();
        drive(1'b0, 1'b1, 4'hF);
        exp_q = sb.pop_front();
        compared++;
        if (q1 !== 1'b1 || {q1, q4, q4r} !== exp_q) begin
            mismatched++;
            $display("FAIL mid_reset_setup: got %b required %b", {q1, q4, q4r}, exp_q);
        end
        drive(1'b1, 1'b1, 4'hF);
        exp_q = sb.pop_front();
        compared++;
        if (q1 !== 1'b0 || {q1, q4, q4r} !== exp_q) begin
            mismatched++;
            $display("FAIL mid_reset_wins: got %b required %b", {q1, q4, q4r}, exp_q);
        end
        drive(1'b0, 1'b1, 4'hF);
        exp_q = sb.pop_front();
        compared++;
        if (q1 !== 1'b1 || q4r !== ~RST_ALT || {q1, q4, q4r} !== exp_q) begin
            mismatched++;
            $display("FAIL mid_reset_release: got %b required %b", {q1, q4, q4r}, exp_q);
        end
    endtask

    task automatic test_random();
        logic rst;
        for (int i = 0; i < 50; i++) begin
            rst = ($urandom_range(9, 0) == 0);
            drive(rst, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)));
            exp_q = sb.pop_front();
            compared++;
            if ({q1, q4, q4r} !== exp_q) begin
                mismatched++;
                $display("FAIL random edge %0d: got %b required %b", i, {q1, q4, q4r}, exp_q);
            end
            // T moves between edges; q must not react until the next posedge.
            #10;
            t1 = ~t1;
            t4 = ~t4;
            #5;
            compared++;
            if ({q1, q4, q4r} !== exp_q) begin
                mismatched++;
                $display("FAIL random_midperiod %0d: got %b required %b", i, {q1, q4, q4r}, exp_q);
            end
        end
    endtask

    initial begin
        reset_n = 1'b1;
        t1      = '0;
        t4      = '0;
        test_reset();
        test_hold();
        test_toggle();
        test_mixed();
        test_mid_reset();
        test_random();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
